// File: rtl/chan_err_pkg.sv
// Shared types and constants for the channel error injector.
package chan_err_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_RAND     = 2'd1,
        MODE_BURST    = 2'd2,
        MODE_PERIODIC = 2'd3
    } err_mode_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } burst_state_t;

    // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
    localparam logic [15:0] LFSR_POLY16  = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Right-shifting Galois LFSR, advancing one step per enabled cycle.
module lfsr_gen
    import chan_err_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(LFSR_POLY16),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    // An all-zero state would lock up the register
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

    always_ff @(posedge clk) begin
        if (rst)
            state <= SEED_EFF;
        else if (step)
            state <= (state >> 1) ^ (state[0] ? POLY : '0);
    end

endmodule

// File: rtl/channel_err_inj.sv
// Pass-through symbol stage that corrupts selected symbols (random, burst or
// periodic) and keeps saturating injection statistics.
module channel_err_inj
    import chan_err_pkg::*;
#(
    parameter int                SYM_W     = 2,
    parameter int                PROB_BITS = 3,
    parameter int                MAX_BURST = 8,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEFAULT_SEED),
    parameter int                WINDOW    = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       cfg_mode,
    input  logic [SYM_W-1:0]                 cfg_mask,
    input  logic [$clog2(MAX_BURST+1)-1:0]   cfg_burst_len,
    input  logic [7:0]                       cfg_period,
    input  logic                             clr_stats,
    input  logic                             sym_valid_i,
    input  logic [SYM_W-1:0]                 sym_i,
    output logic                             sym_valid_o,
    output logic [SYM_W-1:0]                 sym_o,
    output logic                             err_flag_o,
    output logic                             window_active_o,
    output logic [31:0]                      sym_cnt_o,
    output logic [31:0]                      inj_sym_cnt_o,
    output logic [31:0]                      inj_bit_cnt_o,
    output logic [15:0]                      burst_cnt_o
);

    localparam int BL_W = $clog2(MAX_BURST + 1);

    logic [LFSR_W-1:0] lfsr;
    err_mode_t         mode;
    burst_state_t      state, state_n;
    logic [BL_W-1:0]   remain, remain_n, blen;
    logic [SYM_W-1:0]  bmask, bmask_n, use_mask;
    logic [7:0]        pcnt, pcnt_n;
    logic              win, trig, per_hit, corrupt, burst_start;
    logic [32:0]       bit_sum;

    lfsr_gen #(
        .WIDTH (LFSR_W),
        .POLY  (LFSR_W'(LFSR_POLY16)),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (sym_valid_i),
        .state (lfsr)
    );

    assign mode            = err_mode_t'(cfg_mode);
    assign win             = (WINDOW == 0) || (sym_cnt_o < 32'(WINDOW));
    assign window_active_o = win;
    assign trig            = win && (&lfsr[PROB_BITS-1:0]);
    assign per_hit         = (cfg_period != 8'd0) && (pcnt == cfg_period - 8'd1);

    always_comb begin
        blen = cfg_burst_len;
        if (cfg_burst_len == '0)
            blen = BL_W'(1);
        else if (cfg_burst_len > BL_W'(MAX_BURST))
            blen = BL_W'(MAX_BURST);
    end

    always_comb begin
        state_n     = state;
        remain_n    = remain;
        bmask_n     = bmask;
        pcnt_n      = pcnt;
        corrupt     = 1'b0;
        burst_start = 1'b0;
        use_mask    = cfg_mask;
        if (sym_valid_i) begin
            if (mode == MODE_PERIODIC && cfg_period != 8'd0)
                pcnt_n = (pcnt >= cfg_period - 8'd1) ? 8'd0 : pcnt + 8'd1;
            else
                pcnt_n = 8'd0;
        end
        if (mode == MODE_OFF) begin
            state_n = S_IDLE;
        end else if (sym_valid_i) begin
            // An active burst drains under any non-off mode; the window gates starts only
            if (state == S_BURST) begin
                corrupt  = 1'b1;
                use_mask = bmask;
                remain_n = remain - BL_W'(1);
                if (remain == BL_W'(1)) state_n = S_IDLE;
            end else begin
                case (mode)
                    MODE_RAND:     corrupt = trig;
                    MODE_BURST: begin
                        if (trig) begin
                            corrupt     = 1'b1;
                            burst_start = 1'b1;
                            bmask_n     = cfg_mask;
                            remain_n    = blen - BL_W'(1);
                            if (blen > BL_W'(1)) state_n = S_BURST;
                        end
                    end
                    MODE_PERIODIC: corrupt = win && per_hit;
                    default:       corrupt = 1'b0;
                endcase
            end
        end
    end

    assign bit_sum = {1'b0, inj_bit_cnt_o} + 33'(popcount(32'(use_mask)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            remain        <= '0;
            bmask         <= '0;
            pcnt          <= '0;
            sym_valid_o   <= 1'b0;
            sym_o         <= '0;
            err_flag_o    <= 1'b0;
            sym_cnt_o     <= '0;
            inj_sym_cnt_o <= '0;
            inj_bit_cnt_o <= '0;
            burst_cnt_o   <= '0;
        end else begin
            state       <= state_n;
            remain      <= remain_n;
            bmask       <= bmask_n;
            pcnt        <= pcnt_n;
            sym_valid_o <= sym_valid_i;
            sym_o       <= sym_i ^ (use_mask & {SYM_W{corrupt}});
            err_flag_o  <= corrupt;
            if (clr_stats) begin
                sym_cnt_o     <= '0;
                inj_sym_cnt_o <= '0;
                inj_bit_cnt_o <= '0;
                burst_cnt_o   <= '0;
            end else if (sym_valid_i) begin
                if (~&sym_cnt_o) sym_cnt_o <= sym_cnt_o + 32'd1;
                if (corrupt) begin
                    if (~&inj_sym_cnt_o) inj_sym_cnt_o <= inj_sym_cnt_o + 32'd1;
                    inj_bit_cnt_o <= bit_sum[32] ? '1 : bit_sum[31:0];
                end
                if (burst_start && ~&burst_cnt_o) burst_cnt_o <= burst_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_channel_err_inj.sv
// Randomized bench for channel_err_inj against a behavioural error-position model.
module tb_channel_err_inj;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [1:0]  cfg_mask = 2'd0;
    logic [3:0]  cfg_burst_len = 4'd1;
    logic [7:0]  cfg_period = 8'd0;
    logic        clr_stats = 1'b0;
    logic        sym_valid_i = 1'b0;
    logic [1:0]  sym_i = 2'd0;
    logic        sym_valid_o, err_flag_o, window_active_o;
    logic [1:0]  sym_o;
    logic [31:0] sym_cnt_o, inj_sym_cnt_o, inj_bit_cnt_o;
    logic [15:0] burst_cnt_o;

    int checks = 0;
    int errors = 0;

    // model state: LFSR value, symbols still owed by an open burst, symbols seen in periodic mode
    logic [15:0] m_lfsr;
    int          m_left, m_pidx;
    logic [1:0]  m_bmask;
    logic [31:0] m_syms, m_inj, m_bits;
    logic [15:0] m_bursts;
    logic        exp_vld, exp_err;
    logic [1:0]  exp_sym;

    channel_err_inj dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_mask(cfg_mask),
        .cfg_burst_len(cfg_burst_len), .cfg_period(cfg_period), .clr_stats(clr_stats),
        .sym_valid_i(sym_valid_i), .sym_i(sym_i), .sym_valid_o(sym_valid_o), .sym_o(sym_o),
        .err_flag_o(err_flag_o), .window_active_o(window_active_o), .sym_cnt_o(sym_cnt_o),
        .inj_sym_cnt_o(inj_sym_cnt_o), .inj_bit_cnt_o(inj_bit_cnt_o), .burst_cnt_o(burst_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_lfsr = 16'hACE1; m_left = 0; m_pidx = 0; m_bmask = 2'd0;
        m_syms = 0; m_inj = 0; m_bits = 0; m_bursts = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; sym_valid_i = 1'b1; sym_i = 2'($urandom_range(0, 3)); clr_stats = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; sym_valid_i = 1'b0;
        model_reset();
    endtask

    // Drive one cycle and work out from the error rules what the DUT must show after the edge
    task automatic send(input logic v, input logic [1:0] s, input logic clr);
        logic c, win, trig;
        logic [1:0] mk;
        int L;
        sym_valid_i = v; sym_i = s; clr_stats = clr;
        c = 1'b0; mk = cfg_mask;
        win = (m_syms < 256);
        trig = win && ((m_lfsr % 8) == 7);
        if (cfg_mode == 2'd0) m_left = 0;
        else if (v) begin
            if (m_left > 0) begin
                c = 1'b1; mk = m_bmask; m_left--;
            end else if (cfg_mode == 2'd1) c = trig;
            else if (cfg_mode == 2'd2) begin
                if (trig) begin
                    L = (cfg_burst_len == 0) ? 1 : (cfg_burst_len > 8 ? 8 : int'(cfg_burst_len));
                    c = 1'b1; m_bmask = cfg_mask; m_left = L - 1; m_bursts++;
                end
            end else
                c = win && cfg_period != 0 && (m_pidx % int'(cfg_period)) == int'(cfg_period) - 1;
        end
        if (v) begin
            m_pidx = (cfg_mode == 2'd3 && cfg_period != 0) ? m_pidx + 1 : 0;
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
            m_syms++;
            if (c) begin m_inj++; m_bits += 32'($countones(mk)); end
        end
        if (clr) begin m_syms = 0; m_inj = 0; m_bits = 0; m_bursts = 0; end
        exp_vld = v; exp_err = c; exp_sym = c ? (s ^ mk) : s;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        cfg_mode = 2'd2; cfg_mask = 2'd3;
        do_reset();
        checks++;
        if ({sym_valid_o, sym_o, err_flag_o, window_active_o} !== 5'b00001 ||
            {sym_cnt_o, inj_sym_cnt_o, inj_bit_cnt_o, burst_cnt_o} !== 112'd0) begin
            errors++;
            $display("FAIL reset: vld=%b sym=%b err=%b win=%b cnt=%0d/%0d/%0d/%0d, want 0 0 0 1 0/0/0/0",
                     sym_valid_o, sym_o, err_flag_o, window_active_o, sym_cnt_o, inj_sym_cnt_o,
                     inj_bit_cnt_o, burst_cnt_o);
        end
    endtask

    task automatic test_passthrough();
        do_reset();
        cfg_mode = 2'd0; cfg_mask = 2'd3;
        for (int i = 0; i < 300; i++) begin
            send(1'b1, 2'($urandom_range(0, 3)), 1'b0);
            checks++;
            if (err_flag_o !== 1'b0 || sym_o !== exp_sym || sym_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL passthrough sym %0d: err=%b sym=%b vld=%b, want 0 %b 1",
                         i, err_flag_o, sym_o, sym_valid_o, exp_sym);
            end
        end
        checks++;
        if (sym_cnt_o !== 32'd300 || inj_sym_cnt_o !== 0 || inj_bit_cnt_o !== 0 || burst_cnt_o !== 0) begin
            errors++;
            $display("FAIL passthrough counters: %0d/%0d/%0d/%0d, want 300/0/0/0",
                     sym_cnt_o, inj_sym_cnt_o, inj_bit_cnt_o, burst_cnt_o);
        end
    endtask

    task automatic test_periodic();
        do_reset();
        cfg_mode = 2'd3; cfg_period = 8'd4; cfg_mask = 2'b01;
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 2'($urandom_range(0, 3)), 1'b0);
            checks++;
            if (err_flag_o !== ((i % 4) == 3) || err_flag_o !== exp_err || sym_o !== exp_sym) begin
                errors++;
                $display("FAIL periodic sym %0d: err=%b sym=%b, want err=%b sym=%b",
                         i, err_flag_o, sym_o, exp_err, exp_sym);
            end
        end
        checks++;
        if (inj_sym_cnt_o !== 32'd4 || inj_bit_cnt_o !== 32'd4 || sym_cnt_o !== 32'd16) begin
            errors++;
            $display("FAIL periodic counters: inj=%0d bits=%0d syms=%0d, want 4 4 16",
                     inj_sym_cnt_o, inj_bit_cnt_o, sym_cnt_o);
        end
    endtask

    task automatic test_burst();
        bit found = 0;
        do_reset();
        cfg_mode = 2'd2; cfg_burst_len = 4'd3; cfg_mask = 2'b11;
        for (int i = 0; i < 200 && !found; i++) begin
            send(1'b1, 2'($urandom_range(0, 3)), 1'b0);
            found = exp_err;
            checks++;
            if (err_flag_o !== exp_err || sym_o !== exp_sym) begin
                errors++;
                $display("FAIL burst wait sym %0d: err=%b sym=%b, want err=%b sym=%b",
                         i, err_flag_o, sym_o, exp_err, exp_sym);
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL burst start: no trigger within 200 symbols, want one"); end
        for (int i = 0; i < 4; i++) begin
            send(i >= 2, 2'($urandom_range(0, 3)), 1'b0);
            checks++;
            if (err_flag_o !== (i >= 2) || sym_o !== exp_sym || sym_valid_o !== (i >= 2)) begin
                errors++;
                $display("FAIL burst body %0d: err=%b sym=%b vld=%b, want err=%b sym=%b",
                         i, err_flag_o, sym_o, sym_valid_o, i >= 2, exp_sym);
            end
        end
        checks++;
        if (burst_cnt_o !== 16'd1 || inj_sym_cnt_o !== 32'd3 || inj_bit_cnt_o !== 32'd6) begin
            errors++;
            $display("FAIL burst counters: bursts=%0d inj=%0d bits=%0d, want 1 3 6",
                     burst_cnt_o, inj_sym_cnt_o, inj_bit_cnt_o);
        end
        for (int i = 0; i < 150; i++) begin
            cfg_burst_len = 4'($urandom_range(0, 15));
            cfg_mask = 2'($urandom_range(1, 3));
            send($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'b0);
            checks++;
            if (err_flag_o !== exp_err || sym_o !== exp_sym || sym_valid_o !== exp_vld) begin
                errors++;
                $display("FAIL burst random %0d: err=%b sym=%b vld=%b, want err=%b sym=%b vld=%b",
                         i, err_flag_o, sym_o, sym_valid_o, exp_err, exp_sym, exp_vld);
            end
        end
        checks++;
        if ({sym_cnt_o, inj_sym_cnt_o, inj_bit_cnt_o, burst_cnt_o} !== {m_syms, m_inj, m_bits, m_bursts}) begin
            errors++;
            $display("FAIL burst random counters: %0d/%0d/%0d/%0d, want %0d/%0d/%0d/%0d",
                     sym_cnt_o, inj_sym_cnt_o, inj_bit_cnt_o, burst_cnt_o, m_syms, m_inj, m_bits, m_bursts);
        end
    endtask

    task automatic test_random_window();
        do_reset();
        cfg_mode = 2'd1; cfg_mask = 2'($urandom_range(1, 3));
        for (int i = 0; i < 1000; i++) begin
            send(1'b1, 2'($urandom_range(0, 3)), 1'b0);
            checks++;
            if (err_flag_o !== exp_err || sym_o !== exp_sym || (i >= 256 && err_flag_o) ||
                window_active_o !== (i < 255)) begin
                errors++;
                $display("FAIL random sym %0d: err=%b sym=%b win=%b, want err=%b sym=%b win=%b",
                         i, err_flag_o, sym_o, window_active_o, exp_err, exp_sym, i < 255);
            end
        end
        checks++;
        if (sym_cnt_o !== 32'd1000 || inj_sym_cnt_o !== m_inj || inj_bit_cnt_o !== m_bits) begin
            errors++;
            $display("FAIL random counters: syms=%0d inj=%0d bits=%0d, want 1000 %0d %0d",
                     sym_cnt_o, inj_sym_cnt_o, inj_bit_cnt_o, m_inj, m_bits);
        end
    endtask

    task automatic test_reset_replay();
        logic [1:0] stim [60];
        logic       fa [60];
        bit         in_burst = 0;
        for (int i = 0; i < 60; i++) stim[i] = 2'($urandom_range(0, 3));
        do_reset();
        cfg_mode = 2'd2; cfg_burst_len = 4'd5; cfg_mask = 2'b11;
        for (int i = 0; i < 200 && !in_burst; i++) begin
            send(1'b1, 2'($urandom_range(0, 3)), 1'b0);
            in_burst = (m_left > 0);
        end
        checks++;
        if (!in_burst) begin errors++; $display("FAIL replay: no burst within 200 symbols, want one"); end
        do_reset();
        checks++;
        if ({sym_valid_o, sym_o, err_flag_o} !== 4'd0 || burst_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL reset mid-burst: vld=%b sym=%b err=%b bursts=%0d, want 0 0 0 0",
                     sym_valid_o, sym_o, err_flag_o, burst_cnt_o);
        end
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) do_reset();
            for (int i = 0; i < 60; i++) begin
                send(1'b1, stim[i], 1'b0);
                checks++;
                if (err_flag_o !== exp_err || sym_o !== exp_sym || (pass == 1 && err_flag_o !== fa[i])) begin
                    errors++;
                    $display("FAIL replay pass %0d sym %0d: err=%b sym=%b, want err=%b sym=%b",
                             pass, i, err_flag_o, sym_o, exp_err, exp_sym);
                end
                if (pass == 0) fa[i] = err_flag_o;
            end
        end
    endtask

    task automatic test_clr_stats();
        do_reset();
        cfg_mode = 2'd3; cfg_period = 8'd2; cfg_mask = 2'b10;
        send(1'b1, 2'b01, 1'b0);
        send(1'b1, 2'b01, 1'b1);
        checks++;
        if (err_flag_o !== 1'b1 || sym_o !== 2'b11 ||
            {sym_cnt_o, inj_sym_cnt_o, inj_bit_cnt_o, burst_cnt_o} !== 112'd0) begin
            errors++;
            $display("FAIL clr on corruption: err=%b sym=%b cnt=%0d/%0d/%0d/%0d, want 1 11 0/0/0/0",
                     err_flag_o, sym_o, sym_cnt_o, inj_sym_cnt_o, inj_bit_cnt_o, burst_cnt_o);
        end
        cfg_mode = 2'd0;
        for (int i = 0; i < 256; i++) send(1'b1, 2'($urandom_range(0, 3)), 1'b0);
        checks++;
        if (window_active_o !== 1'b0 || sym_cnt_o !== 32'd256) begin
            errors++;
            $display("FAIL window close: win=%b syms=%0d, want 0 256", window_active_o, sym_cnt_o);
        end
        send(1'b0, 2'd0, 1'b1);
        checks++;
        if (window_active_o !== 1'b1 || sym_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL window reopen: win=%b syms=%0d, want 1 0", window_active_o, sym_cnt_o);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_passthrough();
        test_periodic();
        test_burst();
        test_random_window();
        test_reset_replay();
        test_clr_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
